ola_trigger_sequencer: RTL
==========================

Name: ola_trigger_sequencer

Overview:
Multi-stage trigger controller for the logic analyzer capture path. Consumes the aligned sample stream together with the per-bit rising/falling edge vectors produced by the edge detector. Evaluates one programmable condition per stage and advances through up to `stages` stages. After the last stage matches and an optional post-trigger delay elapses, it fires a one-cycle trigger pulse to the capture controller.

Parameters:
width, 8, sample/edge vector width and config data width
stage_bits, 2, stage index width; number of stages = 2**stage_bits
delay_width, 8, post-trigger delay counter width (must be <= width)

Ports:
clock  in  1  sole clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  sample/edge vectors valid this cycle
in_sample  in  width  current sample
in_rising  in  width  rising-edge vector, aligned with in_sample
in_falling  in  width  falling-edge vector, aligned with in_sample
arm  in  1  pulse: start sequence at stage 0
disarm  in  1  pulse: abort, return to IDLE
cfg_write  in  1  config write strobe
cfg_stage  in  stage_bits  target stage for per-stage fields
cfg_field  in  3  0 level_mask, 1 level_value, 2 rise_mask, 3 fall_mask, 4 last_stage, 5 delay
cfg_data  in  width  write data
out_fired  out  1  one-cycle trigger pulse
out_triggered  out  1  level: trigger has fired since last arm
out_state  out  2  0 IDLE, 1 ARMED, 2 DELAY, 3 FIRED
out_stage  out  stage_bits  current stage index

Behaviour:
- Reset (reset_n low, async): all config registers 0, state IDLE, stage 0, delay count 0, out_fired 0, out_triggered 0.
- Config: write on clock edge with cfg_write high, only in IDLE or FIRED; ignored in ARMED/DELAY. Field 4 takes cfg_data[stage_bits-1:0], field 5 takes cfg_data[delay_width-1:0]; fields 4/5 ignore cfg_stage. Codes 6 and 7 are ignored.
- Stage k match (combinational, only when in_valid):
  - level_ok = ((in_sample ^ level_value[k]) & level_mask[k]) == 0
  - edge_ok = (rise_mask[k] | fall_mask[k]) == 0, OR |((in_rising & rise_mask[k]) | (in_falling & fall_mask[k]))
  - match = in_valid & level_ok & edge_ok
- FSM:
  - IDLE: arm -> ARMED, stage 0, out_triggered cleared.
  - ARMED: on match with stage < last_stage, stage+1. Stages advance at most one per valid sample: the same sample is never tested against the next stage. On match with stage == last_stage: delay == 0 -> FIRED; else -> DELAY with count = delay.
  - DELAY: each in_valid cycle decrements count; the valid cycle in which count == 1 -> FIRED. Invalid cycles do not count.
  - FIRED: holds; out_stage keeps last_stage value; arm re-arms.
- out_fired: registered, high for exactly one cycle, the first cycle in FIRED. out_triggered is set with it and held until the next arm or reset.
- Latency: final match in cycle t with delay 0 -> out_fired high in cycle t+1. With delay D, fires in the cycle after the D-th valid sample following the match.
- Priority: disarm > arm > match/count. disarm in any state -> IDLE, stage 0, out_triggered unchanged. arm in ARMED/DELAY/FIRED restarts at stage 0 and ignores a same-cycle match.
- last_stage set to a value is always legal; stage compare is equality.
- Reset mid-sequence aborts immediately with no fire.

Test Plan:
1. Reset: hold reset_n low mid-DELAY -> out_state 0, out_fired 0, out_triggered 0 asynchronously; config reads back as matching-all (mask 0).
2. Single level stage: level_mask=FF, level_value=5A, last_stage=0, delay=0; arm; samples 00,5A -> out_fired pulses one cycle after 5A, out_triggered stays 1, out_state 3.
3. Two-stage edges: stage0 rise_mask=01, stage1 fall_mask=80, last_stage=1. A sample with rising[0] and falling[7] together -> only stage 1 reached. A later falling[7] -> fires.
4. Delay: delay=3, in_valid gapped (1,0,1,0,0,1) after match -> fires in the cycle after the 3rd valid sample, not earlier.
5. Control: cfg write to level_mask while ARMED is ignored. disarm during DELAY -> IDLE, no pulse. arm+disarm same cycle -> IDLE.
6. Re-arm from FIRED: arm -> out_triggered 0, stage 0. A matching sample in the same cycle as arm does not advance.

Source files
------------

// File: rtl/ola_trigger_sequencer.sv
// Multi-stage trigger sequencer for the logic analyzer capture path.
// Each stage tests a masked level pattern plus an optional edge condition
// on the aligned sample stream. After the last stage matches and an
// optional post-trigger delay (counted in valid samples) elapses, a
// one-cycle trigger pulse goes to the capture controller.
module ola_trigger_sequencer #(
    parameter int width       = 8,
    parameter int stage_bits  = 2,
    parameter int delay_width = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [width-1:0]      in_sample,
    input  logic [width-1:0]      in_rising,
    input  logic [width-1:0]      in_falling,
    input  logic                  arm,
    input  logic                  disarm,
    input  logic                  cfg_write,
    input  logic [stage_bits-1:0] cfg_stage,
    input  logic [2:0]            cfg_field,
    input  logic [width-1:0]      cfg_data,
    output logic                  out_fired,
    output logic                  out_triggered,
    output logic [1:0]            out_state,
    output logic [stage_bits-1:0] out_stage
);

    localparam int NSTG = 2 ** stage_bits;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DELAY = 2'd2,
        FIRED = 2'd3
    } state_e;

    // Per-stage condition registers plus global sequence settings
    logic [NSTG-1:0][width-1:0] lvl_mask_q, lvl_mask_d;
    logic [NSTG-1:0][width-1:0] lvl_val_q,  lvl_val_d;
    logic [NSTG-1:0][width-1:0] rise_mask_q, rise_mask_d;
    logic [NSTG-1:0][width-1:0] fall_mask_q, fall_mask_d;
    logic [stage_bits-1:0]      last_q, last_d;
    logic [delay_width-1:0]     dly_q, dly_d;

    // Sequencer state
    state_e                state_q, state_d;
    logic [stage_bits-1:0] stage_q, stage_d;
    logic [delay_width-1:0] cnt_q, cnt_d;
    logic                  fired_q, fired_d;
    logic                  trig_q, trig_d;

    logic cfg_en;
    logic level_ok, edge_ok, match;

    // Config writes land only while the sequencer is not running, so a
    // live sequence never sees its conditions change underneath it.
    always_comb begin
        lvl_mask_d  = lvl_mask_q;
        lvl_val_d   = lvl_val_q;
        rise_mask_d = rise_mask_q;
        fall_mask_d = fall_mask_q;
        last_d      = last_q;
        dly_d       = dly_q;
        cfg_en      = cfg_write && (state_q == IDLE || state_q == FIRED);
        if (cfg_en) begin
            case (cfg_field)
                3'd0:    lvl_mask_d[cfg_stage]  = cfg_data;
                3'd1:    lvl_val_d[cfg_stage]   = cfg_data;
                3'd2:    rise_mask_d[cfg_stage] = cfg_data;
                3'd3:    fall_mask_d[cfg_stage] = cfg_data;
                3'd4:    last_d = cfg_data[stage_bits-1:0];
                3'd5:    dly_d  = cfg_data[delay_width-1:0];
                default: ;
            endcase
        end
    end

    // Current-stage condition; empty edge masks mean "no edge required"
    always_comb begin
        level_ok = ((in_sample ^ lvl_val_q[stage_q]) & lvl_mask_q[stage_q]) == '0;
        edge_ok  = ((rise_mask_q[stage_q] | fall_mask_q[stage_q]) == '0) ||
                   (|((in_rising & rise_mask_q[stage_q]) | (in_falling & fall_mask_q[stage_q])));
        match    = in_valid && level_ok && edge_ok;
    end

    // Next-state: disarm beats arm beats match/count; one stage per sample
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        trig_d  = trig_q;
        fired_d = 1'b0;
        if (disarm) begin
            state_d = IDLE;
            stage_d = '0;
            cnt_d   = '0;
        end else if (arm) begin
            state_d = ARMED;
            stage_d = '0;
            cnt_d   = '0;
            trig_d  = 1'b0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (match) begin
                        if (stage_q == last_q) begin
                            if (dly_q == '0) begin
                                state_d = FIRED;
                            end else begin
                                state_d = DELAY;
                                cnt_d   = dly_q;
                            end
                        end else begin
                            stage_d = stage_q + stage_bits'(1);
                        end
                    end
                end
                DELAY: begin
                    if (in_valid) begin
                        if (cnt_q == delay_width'(1)) begin
                            state_d = FIRED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - delay_width'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
        // Pulse only on the entry into FIRED
        fired_d = (state_d == FIRED) && (state_q != FIRED);
        if (fired_d) trig_d = 1'b1;
    end

    // State and config registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lvl_mask_q  <= '0;
            lvl_val_q   <= '0;
            rise_mask_q <= '0;
            fall_mask_q <= '0;
            last_q      <= '0;
            dly_q       <= '0;
            state_q     <= IDLE;
            stage_q     <= '0;
            cnt_q       <= '0;
            fired_q     <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            lvl_mask_q  <= lvl_mask_d;
            lvl_val_q   <= lvl_val_d;
            rise_mask_q <= rise_mask_d;
            fall_mask_q <= fall_mask_d;
            last_q      <= last_d;
            dly_q       <= dly_d;
            state_q     <= state_d;
            stage_q     <= stage_d;
            cnt_q       <= cnt_d;
            fired_q     <= fired_d;
            trig_q      <= trig_d;
        end
    end

    assign out_fired     = fired_q;
    assign out_triggered = trig_q;
    assign out_state     = state_q;
    assign out_stage     = stage_q;

endmodule
